// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one 8N1-style UART transmit line between NUM_REQ byte requesters.
// A round-robin arbiter picks one requester in each IDLE cycle and hands its
// byte to a four-state serializer:
//   start bit, DATA_W data bits LSB first, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks.
// tx and busy are registered, so the line changes one clock after the
// handshake edge. req_ready is combinational and is only ever asserted in IDLE.

module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;

    logic                any_valid;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     idx;
    logic                baud_end;

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Round-robin pick: first valid index scanning upward from last_grant+1,
    // wrapping at NUM_REQ; last_grant itself is visited last.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    // One-hot accept strobe: only in IDLE, and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && any_valid) begin
            req_ready = NUM_REQ'(1) << pick;
        end
    end

    // Next-state and next-output logic for the serializer FSM.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        grant_d = grant_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (any_valid) begin
                    state_d = START;
                    shift_d = req_data[int'(pick)*DATA_W +: DATA_W];
                    grant_d = pick;
                    last_d  = pick;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next data bit is the new LSB once the register shifts.
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state register; reset aborts any frame in progress and restores
    // priority so that requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Data shift register; contents only matter after a handshake loads it.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule
